// File: rtl/burst_read_engine.sv
// Burst read engine: on rd, reads BURST_LEN consecutive words from a fixed-latency memory
// and streams them out through a credit-protected FWFT FIFO with a last marker.
module burst_read_engine #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 16,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic [AW-1:0] rd_addr,
    output logic          busy,
    output logic          done,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready
);

    localparam int unsigned IW = $clog2(BURST_LEN + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    base_q, addr_hold_q, issue_addr;
    logic [IW-1:0]    issued_q, beat_q;
    logic [CW-1:0]    fifo_cnt_q, inflight_q;
    logic [CW:0]      credit_used;
    logic [MEM_LAT-1:0] ret_vld_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [DW-1:0]    fifo_mem [FIFO_DEPTH];
    logic             issue, push, pop, last_beat;

    // Credit covers words already queued plus words still travelling through memory.
    assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign issue_addr  = base_q + AW'(issued_q);
    assign push        = ret_vld_q[MEM_LAT-1];
    assign out_valid   = (fifo_cnt_q != '0);
    assign pop         = out_valid & out_ready;
    assign out_data    = out_valid ? fifo_mem[rd_ptr_q] : '0;
    assign last_beat   = (beat_q == IW'(BURST_LEN - 1));
    assign out_last    = out_valid & last_beat;
    assign mem_en      = issue;
    assign mem_addr    = issue ? issue_addr : addr_hold_q;

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (rd) state_d = StIssue;
            end
            StIssue: begin
                issue = (issued_q < IW'(BURST_LEN)) && (credit_used < (CW+1)'(FIFO_DEPTH));
                if (issue && issued_q == IW'(BURST_LEN - 1)) state_d = StWait;
            end
            StWait: begin
                if (pop && last_beat) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            addr_hold_q <= '0;
            issued_q    <= '0;
            beat_q      <= '0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            ret_vld_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && rd) begin
                base_q   <= rd_addr;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + 1'b1;
            end
            if (issue) addr_hold_q <= issue_addr;
            ret_vld_q[0] <= issue;
            for (int i = 1; i < MEM_LAT; i++) ret_vld_q[i] <= ret_vld_q[i-1];
            if (issue && !push) inflight_q <= inflight_q + 1'b1;
            else if (!issue && push) inflight_q <= inflight_q - 1'b1;
            if (push && !pop) fifo_cnt_q <= fifo_cnt_q + 1'b1;
            else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
            if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                beat_q   <= last_beat ? '0 : beat_q + 1'b1;
            end
        end
    end

    // Storage is not reset; out_data is gated by out_valid instead.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !pop && fifo_cnt_q == CW'(FIFO_DEPTH)));
    end

endmodule

// File: tb/tb_burst_read_engine.sv
// Directed bench for burst_read_engine: cycle-exact timing, backpressure, wrap, rd filtering
// and mid-burst reset, with a scoreboard checking every streamed beat.
module tb_burst_read_engine;
    localparam int AW = 8;
    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          rd_a, busy_a, done_a, mem_en_a, out_valid_a, out_last_a, out_ready_a;
    logic [AW-1:0] rd_addr_a, mem_addr_a;
    logic [DW-1:0] mem_rdata_a, out_data_a;
    logic          rd_b, busy_b, done_b, mem_en_b, out_valid_b, out_last_b, out_ready_b;
    logic [AW-1:0] rd_addr_b, mem_addr_b;
    logic [DW-1:0] mem_rdata_b, out_data_b;
    logic [DW-1:0] pipe_b [3];

    beat_t exp_a[$];
    beat_t exp_b[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    burst_read_engine #(.AW(AW), .DW(DW), .BURST_LEN(4), .MEM_LAT(1), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .rd(rd_a), .rd_addr(rd_addr_a), .busy(busy_a), .done(done_a),
        .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_last(out_last_a),
        .out_ready(out_ready_a)
    );

    burst_read_engine #(.AW(AW), .DW(DW), .BURST_LEN(8), .MEM_LAT(3), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .rd(rd_b), .rd_addr(rd_addr_b), .busy(busy_b), .done(done_b),
        .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b),
        .out_ready(out_ready_b)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    // Memory models: 1-cycle for A, 3-stage for B
    always @(posedge clk) begin
        mem_rdata_a <= mem_word(mem_addr_a);
        pipe_b[0]   <= mem_word(mem_addr_b);
        pipe_b[1]   <= pipe_b[0];
        pipe_b[2]   <= pipe_b[1];
    end
    assign mem_rdata_b = pipe_b[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_a(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) exp_a.push_back('{mem_word(base + AW'(i)), i == n - 1});
    endtask

    task automatic push_b(input logic [AW-1:0] base, input int n);
        for (int i = 0; i < n; i++) exp_b.push_back('{mem_word(base + AW'(i)), i == n - 1});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every transferred beat must match the next expected word.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && out_valid_a && out_ready_a) begin
            check("a_beat_expected", 32'(exp_a.size() != 0), 1);
            if (exp_a.size() != 0) begin
                e = exp_a.pop_front();
                check("a_data", 32'(out_data_a), 32'(e.data));
                check("a_last", 32'(out_last_a), 32'(e.last));
            end
        end
        if (!rst && out_valid_b && out_ready_b) begin
            check("b_beat_expected", 32'(exp_b.size() != 0), 1);
            if (exp_b.size() != 0) begin
                e = exp_b.pop_front();
                check("b_data", 32'(out_data_b), 32'(e.data));
                check("b_last", 32'(out_last_b), 32'(e.last));
            end
        end
    end

    initial begin
        logic [AW-1:0] seen[$];
        logic [AW-1:0] ea;
        int en_cnt, done_cnt, got_done;
        rd_a = 0; rd_addr_a = '0; out_ready_a = 1;
        rd_b = 0; rd_addr_b = '0; out_ready_b = 0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy_a", busy_a, 0);       check("rst_done_a", done_a, 0);
        check("rst_mem_en_a", mem_en_a, 0);   check("rst_mem_addr_a", mem_addr_a, 0);
        check("rst_valid_a", out_valid_a, 0); check("rst_last_a", out_last_a, 0);
        check("rst_data_a", out_data_a, 0);
        check("rst_busy_b", busy_b, 0);       check("rst_mem_en_b", mem_en_b, 0);
        check("rst_valid_b", out_valid_b, 0); check("rst_data_b", out_data_b, 0);
        step(); rst = 0;
        step();

        // Cycle-exact burst at 0x10
        rd_a = 1; rd_addr_a = 8'h10; push_a(8'h10, 4);
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("t1_mem_en_c%0d", c), mem_en_a, 32'(c >= 1 && c <= 4));
            if (c >= 1 && c <= 4)
                check($sformatf("t1_addr_c%0d", c), mem_addr_a, 32'(8'h10 + c - 1));
            check($sformatf("t1_valid_c%0d", c), out_valid_a, 32'(c >= 3 && c <= 6));
            check($sformatf("t1_last_c%0d", c), out_last_a, 32'(c == 6));
            check($sformatf("t1_done_c%0d", c), done_a, 32'(c == 7));
            check($sformatf("t1_busy_c%0d", c), busy_a, 32'(c >= 1 && c <= 7));
            step(); rd_a = 0;
        end

        // Address wrap from 0xFE
        rd_a = 1; rd_addr_a = 8'hFE; push_a(8'hFE, 4); got_done = 0;
        for (int c = 0; c < 30 && got_done == 0; c++) begin
            @(negedge clk);
            if (mem_en_a) seen.push_back(mem_addr_a);
            if (done_a) got_done = 1;
            else begin step(); rd_a = 0; end
        end
        check("t2_done_seen", got_done, 1);
        check("t2_n_reads", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            ea = 8'hFE + AW'(i);
            check($sformatf("t2_addr%0d", i), seen[i], ea);
        end
        step();

        // rd held through the burst; rd_addr changes ignored; re-accept in IDLE after done
        rd_a = 1; rd_addr_a = 8'h40; push_a(8'h40, 4); en_cnt = 0; done_cnt = 0;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            en_cnt += int'(mem_en_a); done_cnt += int'(done_a);
            step(); rd_addr_a = 8'h99;
        end
        check("t3_n_reads", en_cnt, 4);
        check("t3_n_done", done_cnt, 1);
        rd_addr_a = 8'h80; push_a(8'h80, 4);
        @(negedge clk);
        check("t3_idle_busy", busy_a, 0);
        step(); rd_a = 0;
        @(negedge clk);
        check("t3_restart_busy", busy_a, 1);
        check("t3_restart_en", mem_en_a, 1);
        check("t3_restart_addr", mem_addr_a, 8'h80);
        got_done = 0;
        for (int c = 0; c < 30 && got_done == 0; c++) begin
            step(); @(negedge clk);
            if (done_a) got_done = 1;
        end
        check("t3_done2", got_done, 1);
        check("a_sb_empty", exp_a.size(), 0);

        // Backpressure on B: only FIFO_DEPTH reads may issue
        step();
        rd_b = 1; rd_addr_b = 8'h20; push_b(8'h20, 8); en_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            en_cnt += int'(mem_en_b);
            step(); rd_b = 0;
        end
        check("t4_reads_stalled", en_cnt, 4);
        @(negedge clk);
        check("t4_hold_valid", out_valid_b, 1);
        check("t4_hold_data", out_data_b, 32'(mem_word(8'h20)));
        check("t4_hold_last", out_last_b, 0);
        check("t4_hold_en", mem_en_b, 0);
        got_done = 0;
        for (int c = 0; c < 150 && got_done < 4; c++) begin
            step(); out_ready_b = ~out_ready_b;
            @(negedge clk);
            en_cnt += int'(mem_en_b); done_cnt += int'(done_b);
            if (done_cnt != 0) got_done++;
        end
        check("t4_total_reads", en_cnt, 8);
        check("t4_n_done", done_cnt, 1);
        check("b_sb_empty", exp_b.size(), 0);

        // Reset with reads in flight
        step(); out_ready_b = 1;
        rd_b = 1; rd_addr_b = 8'h30; push_b(8'h30, 8);
        step(); rd_b = 0;
        step();
        @(negedge clk);
        check("t5_second_issue", mem_en_b, 1);
        step(); rst = 1; exp_b.delete();
        @(negedge clk);
        check("t5_busy", busy_b, 0);       check("t5_done", done_b, 0);
        check("t5_mem_en", mem_en_b, 0);   check("t5_mem_addr", mem_addr_b, 0);
        check("t5_valid", out_valid_b, 0); check("t5_last", out_last_b, 0);
        check("t5_data", out_data_b, 0);
        step(); step(); rst = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("t5_no_stale_c%0d", c), out_valid_b, 0);
            step();
        end
        rd_b = 1; rd_addr_b = 8'h50; push_b(8'h50, 8); got_done = 0;
        for (int c = 0; c < 60 && got_done == 0; c++) begin
            step(); rd_b = 0;
            @(negedge clk);
            if (done_b) got_done = 1;
        end
        check("t5_after_rst_done", got_done, 1);
        check("t5_sb_empty", exp_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
